// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   state_e              : fetch FSM encodings (S_IDLE, S_REQ, S_READ)
//   RESET_PC_DEFAULT     : default PC loaded on reset
//   ICACHE_LINES_DEFAULT : default icache depth (used only with INST_FETCH_ICACHE_EN)
//   next_pc()            : sequential PC step, 32-bit modulo
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_READ = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT     = 32'h0000_0000;
  localparam int          ICACHE_LINES_DEFAULT = 16;

  // Wraps 32'hFFFF_FFFC -> 0 by plain 32-bit overflow; no alignment check.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Byte-wide memory port between the fetch stage (master) and the memory
// arbiter (slave).
//   mem_req : master requests ownership of the port
//   mem_gnt : arbiter grant, held while mem_req stays high
//   mem_a   : byte address driven by the master
//   mem_din : byte read for the address driven on the previous cycle
interface inst_fetch_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;

  modport master (output mem_req, output mem_a, input mem_gnt, input mem_din);
  modport slave  (input mem_req, input mem_a, output mem_gnt, output mem_din);
endinterface

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line. Built only when
// INST_FETCH_ICACHE_EN is defined.
//   clk, rst : clock, async active-high reset (clears valid bits only)
//   rd_word  : word address (pc[31:2]) for the combinational lookup
//   hit      : line valid and tag matches
//   rd_data  : cached word for rd_word
//   wr_en    : write rd/wr line on this clock edge
//   wr_word  : word address to fill
//   wr_data  : word to store
`ifdef INST_FETCH_ICACHE_EN
module inst_fetch_icache #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] rd_word,
  output logic        hit,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [29:0] wr_word,
  input  logic [31:0] wr_data
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  assign rd_idx = rd_word[IDX_W-1:0];
  assign wr_idx = wr_word[IDX_W-1:0];

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_word[29:IDX_W]);
  assign rd_data = data_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid_q         <= '0;
    else if (wr_en) valid_q[wr_idx] <= 1'b1;
  end

  // NOTE: tag/data arrays are deliberately left out of reset; a cleared valid
  // bit already masks their contents, and resetting storage prevents RAM mapping.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_word[29:IDX_W];
      data_q[wr_idx] <= wr_data;
    end
  end
endmodule
`endif

// File: rtl/inst_fetch.sv
// Instruction fetch stage feeding the instruction queue. Reads each 32-bit
// instruction as four little-endian bytes over the shared 8-bit memory port,
// then pushes {inst, pc_out} with a one-cycle inst_rdy strobe.
//   clk, rst       : clock, async active-high reset
//   rdy            : global enable, 0 freezes all state (redirect included)
//   iqueue_full    : queue nearly full, blocks starting a new fetch only
//   redirect_valid : control-flow redirect, highest priority
//   redirect_pc    : new fetch PC
//   bus            : memory port (inst_fetch_if.master)
//   inst_rdy       : push strobe; inst / pc_out valid with it
// Optional feature macro: INST_FETCH_ICACHE_EN adds a direct-mapped icache
// (inst_fetch_icache) that serves hits from S_IDLE without touching memory.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          ICACHE_LINES = ICACHE_LINES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               iqueue_full,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  inst_fetch_if.master       bus,
  output logic               inst_rdy,
  output logic [31:0]        inst,
  output logic [31:0]        pc_out
);

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_check
    $error("ICACHE_LINES must be a power of 2");
  end

  state_e      state;
  logic [31:0] pc;
  logic [2:0]  cnt;
  // Bytes 0..2 of the word in flight, shifted in from the top so byte 0 ends
  // up in [7:0] once byte 2 has arrived; byte 3 is taken straight off mem_din.
  logic [23:0] byte_buf;

  // Registered state decodes directly, so a redirect drops mem_req one cycle later.
  assign bus.mem_req = (state != S_IDLE);
  assign bus.mem_a   = (state == S_READ) ? pc + {30'd0, cnt[1:0]} : pc;

`ifdef INST_FETCH_ICACHE_EN
  logic        ic_hit;
  logic [31:0] ic_data;
  logic        ic_wr;

  // A redirect on the completing cycle discards the word, so it is not cached either.
  assign ic_wr = rdy && !redirect_valid && (state == S_READ) && (cnt == 3'd4);

  inst_fetch_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_word (pc[31:2]),
    .hit     (ic_hit),
    .rd_data (ic_data),
    .wr_en   (ic_wr),
    .wr_word (pc[31:2]),
    .wr_data ({bus.mem_din, byte_buf})
  );
`endif

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      cnt      <= '0;
      byte_buf <= '0;
      inst_rdy <= 1'b0;
      inst     <= '0;
      pc_out   <= '0;
    end else if (!rdy) begin
      inst_rdy <= 1'b0;  // frozen cycle must not repeat the previous push
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      cnt      <= '0;
      byte_buf <= '0;
      inst_rdy <= 1'b0;
      state    <= S_IDLE;
    end else begin
      inst_rdy <= 1'b0;
      unique case (state)
        S_IDLE: begin
`ifdef INST_FETCH_ICACHE_EN
          if (!iqueue_full) begin
            if (!ic_hit) begin
              state <= S_REQ;
            end else if (!inst_rdy) begin
              // One bubble after each hit push so iqueue_full can catch up.
              inst     <= ic_data;
              pc_out   <= pc;
              pc       <= next_pc(pc);
              inst_rdy <= 1'b1;
            end
          end
`else
          if (!iqueue_full) state <= S_REQ;
`endif
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            state <= S_READ;
            cnt   <= '0;
          end
        end
        S_READ: begin
          if (cnt == 3'd4) begin
            inst     <= {bus.mem_din, byte_buf};
            pc_out   <= pc;
            pc       <= next_pc(pc);
            inst_rdy <= 1'b1;
            cnt      <= '0;
            state    <= iqueue_full ? S_IDLE : S_REQ;
          end else begin
            // cnt==0 only drives the first address; data arrives from cnt==1.
            if (cnt != 3'd0) byte_buf <= {bus.mem_din, byte_buf[23:8]};
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: cycle table for the first fetch, hand
// sequences for backpressure/redirect/freeze/wrap (and cache reuse when
// INST_FETCH_ICACHE_EN is defined), then randomized traffic against a
// transaction-level model of the pushed {inst, pc} stream.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        iqueue_full = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_rdy;
  logic [31:0] inst, pc_out;

  int checks = 0;
  int errors = 0;

  inst_fetch_if bus ();

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .iqueue_full    (iqueue_full),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .inst_rdy       (inst_rdy),
    .inst           (inst),
    .pc_out         (pc_out)
  );

  always #5 clk = ~clk;

  // ---------------- memory and arbiter models ----------------
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h00;
      32'd3:   return 8'h00;
      default: begin
        h = a * 32'h9E37_79B1;
        return h[31:24];
      end
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // The whole system shares rdy, so the memory pipeline freezes with it.
  always @(posedge clk) if (rdy) bus.mem_din <= mem_byte(bus.mem_a);

  logic gnt_imm = 1'b1;
  logic gnt_q = 1'b0;
  always @(posedge clk) gnt_q <= bus.mem_req && (gnt_q || ($urandom_range(0, 2) == 0));
  assign bus.mem_gnt = bus.mem_req && (gnt_imm || gnt_q);

  // Arbiter protocol: a grant, once given, is held while the request stays up.
  logic req_d = 1'b0, gnt_d = 1'b0;
  always @(posedge clk) begin
    if (!rst && req_d && gnt_d && bus.mem_req)
      assert (bus.mem_gnt) else $error("arbiter dropped grant during a fetch");
    req_d <= bus.mem_req;
    gnt_d <= bus.mem_gnt;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic imm);
    rst = 1'b1; rdy = 1'b1; iqueue_full = 1'b0; redirect_valid = 1'b0;
    gnt_imm = imm;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_push(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (inst_rdy) break;
    end
    check(name, inst_rdy, 1);
  endtask

  typedef struct {
    logic        full;
    logic        exp_req;
    logic        chk_a;
    logic [31:0] exp_a;
    logic        exp_rdy;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Row 0 is sampled right after reset; row k after the k-th clock edge.
    vecs[0] = '{0, 0, 0, 32'h0, 0, 32'h0,   32'h0};
    vecs[1] = '{0, 1, 1, 32'h0, 0, 32'h0,   32'h0};
    vecs[2] = '{0, 1, 1, 32'h0, 0, 32'h0,   32'h0};
    vecs[3] = '{0, 1, 1, 32'h1, 0, 32'h0,   32'h0};
    vecs[4] = '{0, 1, 1, 32'h2, 0, 32'h0,   32'h0};
    vecs[5] = '{0, 1, 1, 32'h3, 0, 32'h0,   32'h0};
    vecs[6] = '{0, 1, 0, 32'h0, 0, 32'h0,   32'h0};
    vecs[7] = '{0, 1, 1, 32'h4, 1, 32'h513, 32'h0};
    vecs[8] = '{0, 1, 1, 32'h4, 0, 32'h513, 32'h0};

    // 1: reset state and first fetch with immediate grant.
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      iqueue_full = vecs[i].full;
      if (i > 0) tick();
      check($sformatf("t1_req[%0d]", i), bus.mem_req, vecs[i].exp_req);
      if (vecs[i].chk_a) check($sformatf("t1_a[%0d]", i), bus.mem_a, vecs[i].exp_a);
      check($sformatf("t1_rdy[%0d]", i), inst_rdy, vecs[i].exp_rdy);
      check($sformatf("t1_inst[%0d]", i), inst, vecs[i].exp_inst);
      check($sformatf("t1_pc[%0d]", i), pc_out, vecs[i].exp_pc);
    end

    // 2: queue fills mid-fetch; the in-flight word still pushes, then no request.
    do_reset(1'b1);
    repeat (4) tick();
    iqueue_full = 1'b1;
    wait_push("t2_push", 8);
    check("t2_inst", inst, 32'h0000_0513);
    check("t2_pc", pc_out, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("t2_req_blocked", bus.mem_req, 0);
      tick();
      check("t2_no_push", inst_rdy, 0);
    end
    iqueue_full = 1'b0;
    tick();
    check("t2_req_resume", bus.mem_req, 1);
    check("t2_a_resume", bus.mem_a, 32'h4);

    // 3: redirect at cnt==3 kills the word; next fetch reads the target.
    do_reset(1'b1);
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t3_req_drop", bus.mem_req, 0);
    check("t3_no_push", inst_rdy, 0);
    tick();
    check("t3_no_push2", inst_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t3_a%0d", i), bus.mem_a, 32'h100 + i);
    end
    wait_push("t3_push", 8);
    check("t3_pc", pc_out, 32'h100);
    check("t3_inst", inst, mem_word(32'h100));

    // 4: redirect on the completing cycle drops the word.
    do_reset(1'b1);
    repeat (6) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("t4_dropped", inst_rdy, 0);
    check("t4_req_drop", bus.mem_req, 0);
    wait_push("t4_push", 10);
    check("t4_pc", pc_out, 32'h200);
    check("t4_inst", inst, mem_word(32'h200));

    // 5: three frozen cycles mid-read, then exactly one correct push.
    do_reset(1'b1);
    repeat (4) tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_frozen_no_push", inst_rdy, 0);
      check("t5_frozen_a", bus.mem_a, 32'h2);
    end
    rdy = 1'b1;
    iqueue_full = 1'b1;
    begin
      int n = 0;
      logic [31:0] got_inst = '0, got_pc = '1;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (inst_rdy) begin
          n++; got_inst = inst; got_pc = pc_out;
        end
      end
      check("t5_push_count", n, 1);
      check("t5_inst", got_inst, 32'h0000_0513);
      check("t5_pc", got_pc, 32'h0);
    end

    // PC wrap: 32'hFFFFFFFC is followed by 0.
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_push("wrap_push0", 10);
    check("wrap_pc0", pc_out, 32'hFFFF_FFFC);
    check("wrap_inst0", inst, mem_word(32'hFFFF_FFFC));
    wait_push("wrap_push1", 10);
    check("wrap_pc1", pc_out, 32'h0);
    check("wrap_inst1", inst, 32'h0000_0513);

`ifdef INST_FETCH_ICACHE_EN
    // 6: second pass over 0x0..0xC comes from the cache, one push per 2 cycles.
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_push($sformatf("t6_fill%0d", k), 10);
      check($sformatf("t6_fill_pc%0d", k), pc_out, 32'(4 * k));
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    begin
      int reqs = 0, last = 0, cyc = 0;
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 6; i++) begin
          tick(); cyc++;
          if (bus.mem_req) reqs++;
          if (inst_rdy) break;
        end
        check($sformatf("t6_hit_push%0d", k), inst_rdy, 1);
        check($sformatf("t6_hit_pc%0d", k), pc_out, 32'(4 * k));
        check($sformatf("t6_hit_inst%0d", k), inst, mem_word(32'(4 * k)));
        if (k > 0) check($sformatf("t6_gap%0d", k), cyc - last, 2);
        last = cyc;
      end
      check("t6_no_mem_req", reqs, 0);
    end
`endif

    // Randomized traffic against a transaction model of the push stream.
    do_reset(1'b0);
    begin
      logic [31:0] pc_exp = 32'h0;
      logic        p_rdy, p_red;
      logic [31:0] p_rpc;
      int          pushes = 0;
      for (int n = 0; n < 3000; n++) begin
        rdy            = ($urandom_range(0, 9) != 0);
        iqueue_full    = ($urandom_range(0, 3) == 0);
        redirect_valid = ($urandom_range(0, 49) == 0);
        redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
        p_rdy = rdy; p_red = redirect_valid; p_rpc = redirect_pc;
        tick();
        if (!p_rdy) begin
          check("rand_frozen_no_push", inst_rdy, 0);
        end else if (p_red) begin
          check("rand_redirect_no_push", inst_rdy, 0);
          pc_exp = p_rpc;
        end else if (inst_rdy) begin
          check("rand_pc", pc_out, pc_exp);
          check("rand_inst", inst, mem_word(pc_exp));
          pc_exp = pc_exp + 32'd4;
          pushes++;
        end
      end
      check("rand_enough_pushes", (pushes > 50), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
